// File: rtl/waveform_sample_buffer.sv
// Purpose: decimates 8-bit heart-signal samples into one bank of a ping-pong line buffer; display reads the other bank by hcount.
// Latency: a write lands on the 2^LOG2_DECIMATE-th valid sample; signal_out is registered, one cycle after hcount.
// Backpressure: none; a full write bank waiting for frame_start discards decimated samples and sets sticky overflow.
// Optional feature macro WAVEFORM_TRIGGER_EN: fill starts from an ARM state on a rising crossing of TRIGGER_LEVEL.
module waveform_sample_buffer #(
    parameter int WIDTH         = 1024,
    parameter int DATA_W        = 8,
    parameter int LOG2_DECIMATE = 2,
    parameter int TRIGGER_LEVEL = 128
) (
    input  logic              clk_100mhz,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [2:0]        system_status,
    input  logic              frame_start,
    input  logic [10:0]       hcount,
    output logic [DATA_W-1:0] signal_out,
    output logic              buffer_ready,
    output logic [9:0]        write_column,
    output logic              overflow
);

    // Column counter width is fixed by the write_column port; WIDTH must not exceed 1024.
    localparam int COL_W = 10;
    localparam int ACC_W = DATA_W + LOG2_DECIMATE;

    localparam logic [2:0] ST_PAUSED  = 3'd0;
    localparam logic [2:0] ST_RUNNING = 3'd1;

    // Reject parameter sets the datapath cannot represent.
    if (LOG2_DECIMATE < 1 || WIDTH < 2 || WIDTH > 1024 || TRIGGER_LEVEL >= (1 << DATA_W)) begin : g_bad_cfg
        $error("waveform_sample_buffer: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WAIT_SWAP
`ifdef WAVEFORM_TRIGGER_EN
        ,
        S_ARM
`endif
    } state_t;

    state_t                   state_q, state_d;
    logic                     wr_bank_q, wr_bank_d;
    logic [COL_W-1:0]         wcol_q, wcol_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [LOG2_DECIMATE-1:0] cnt_q, cnt_d;
    logic                     buffer_ready_q, buffer_ready_d;
    logic                     overflow_q, overflow_d;
    logic [DATA_W-1:0]        signal_out_q, signal_out_d;
    logic                     run_q;
`ifdef WAVEFORM_TRIGGER_EN
    logic                     prev_lo_q, prev_lo_d;
    logic                     dec_hi;
`endif

    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] dec_val;
    logic              acc_en;
    logic              dec_vld;
    logic              mem_we;
    logic              rd_bank;

    // Bank is the outer index so each bank is a plain WIDTH-deep array; no reset on contents.
    logic [DATA_W-1:0] mem_q [0:1][0:WIDTH-1];

    assign rd_bank = ~wr_bank_q;

    // Decimator datapath and fill/swap FSM next-state.
    always_comb begin
        state_d        = state_q;
        wr_bank_d      = wr_bank_q;
        wcol_d         = wcol_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        buffer_ready_d = buffer_ready_q;
        overflow_d     = overflow_q;
        mem_we         = 1'b0;

        sum     = acc_q + ACC_W'(sample_in);
        dec_val = sum[ACC_W-1:LOG2_DECIMATE];
        // Samples are taken only while running and not in the cycle the status changed to running.
        acc_en  = sample_valid && (system_status == ST_RUNNING) && run_q && (state_q != S_IDLE);
        dec_vld = acc_en && (cnt_q == {LOG2_DECIMATE{1'b1}});
`ifdef WAVEFORM_TRIGGER_EN
        prev_lo_d = prev_lo_q;
        dec_hi    = (int'(dec_val) >= TRIGGER_LEVEL);
        if (dec_vld) begin
            prev_lo_d = !dec_hi;
        end
`endif

        if (acc_en) begin
            if (dec_vld) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (system_status == ST_RUNNING) begin
            case (state_q)
                S_IDLE: begin
`ifdef WAVEFORM_TRIGGER_EN
                    state_d = S_ARM;
`else
                    state_d = S_FILL;
`endif
                    wcol_d = '0;
                    acc_d  = '0;
                    cnt_d  = '0;
                end
                S_FILL: begin
                    if (dec_vld) begin
                        mem_we = 1'b1;
                        if (wcol_q == COL_W'(WIDTH - 1)) begin
                            state_d = S_WAIT_SWAP;
                            wcol_d  = '0;
                        end else begin
                            wcol_d = wcol_q + 1'b1;
                        end
                    end
                end
                S_WAIT_SWAP: begin
                    if (dec_vld) begin
                        overflow_d = 1'b1;
                    end
                    if (frame_start) begin
                        wr_bank_d      = ~wr_bank_q;
                        buffer_ready_d = 1'b1;
`ifdef WAVEFORM_TRIGGER_EN
                        state_d = S_ARM;
`else
                        state_d = S_FILL;
`endif
                    end
                end
`ifdef WAVEFORM_TRIGGER_EN
                S_ARM: begin
                    // The triggering sample itself occupies column 0.
                    if (dec_vld && dec_hi && prev_lo_q) begin
                        mem_we  = 1'b1;
                        wcol_d  = COL_W'(1);
                        state_d = S_FILL;
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (system_status != ST_PAUSED) begin
            state_d = S_IDLE;
            wcol_d  = '0;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef WAVEFORM_TRIGGER_EN
            prev_lo_d = 1'b0;
`endif
        end
    end

    // Registered read of the display bank; out-of-range columns read as zero.
    always_comb begin
        signal_out_d = '0;
        if (hcount < 11'(WIDTH)) begin
            signal_out_d = mem_q[rd_bank][hcount[COL_W-1:0]];
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wr_bank_q      <= 1'b0;
            wcol_q         <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            buffer_ready_q <= 1'b0;
            overflow_q     <= 1'b0;
            signal_out_q   <= '0;
            run_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_bank_q      <= wr_bank_d;
            wcol_q         <= wcol_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            buffer_ready_q <= buffer_ready_d;
            overflow_q     <= overflow_d;
            signal_out_q   <= signal_out_d;
            run_q          <= (system_status == ST_RUNNING);
        end
    end

`ifdef WAVEFORM_TRIGGER_EN
    // Remembers whether the last decimated sample sat below the trigger level.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            prev_lo_q <= 1'b0;
        end else begin
            prev_lo_q <= prev_lo_d;
        end
    end
`endif

    // Single write port into the current write bank.
    always_ff @(posedge clk_100mhz) begin
        if (mem_we) begin
            mem_q[wr_bank_q][wcol_q] <= dec_val;
        end
    end

    assign signal_out   = signal_out_q;
    assign buffer_ready = buffer_ready_q;
    assign write_column = wcol_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_waveform_sample_buffer.sv
// Purpose: directed self-checking bench for waveform_sample_buffer (default build).
// Latency: checks sample outputs 1 time unit after the rising edge that produced them.
// Backpressure: none; stimulus is applied one sample per cycle.
module tb_waveform_sample_buffer;

    logic        clk_100mhz = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [2:0]  system_status = 3'd0;
    logic        frame_start = 1'b0;
    logic [10:0] hcount = '0;
    logic [7:0]  signal_out;
    logic        buffer_ready;
    logic [9:0]  write_column;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    waveform_sample_buffer dut (
        .clk_100mhz   (clk_100mhz),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .system_status(system_status),
        .frame_start  (frame_start),
        .hcount       (hcount),
        .signal_out   (signal_out),
        .buffer_ready (buffer_ready),
        .write_column (write_column),
        .overflow     (overflow)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic push(input logic [7:0] v, input logic fs);
        sample_in    = v;
        sample_valid = 1'b1;
        frame_start  = fs;
        tick();
        sample_valid = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic push_group(input logic [7:0] v, input logic fs_last);
        for (int k = 0; k < 4; k++) begin
            push(v, fs_last && (k == 3));
        end
    endtask

    initial begin
        logic [7:0] colv;
        int         exp_rd;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_val("rst_signal_out", int'(signal_out), 0);
        check_val("rst_buffer_ready", int'(buffer_ready), 0);
        check_val("rst_write_column", int'(write_column), 0);
        check_val("rst_overflow", int'(overflow), 0);

        // Start running: first cycle moves IDLE to FILL
        system_status = 3'd1;
        tick();
        push(8'd10, 1'b0);
        push(8'd20, 1'b0);
        push(8'd30, 1'b0);
        check_val("wc_before_4th", int'(write_column), 0);
        push(8'd41, 1'b0);
        check_val("wc_after_first_avg", int'(write_column), 1);

        // Fill remaining columns with column[7:0]; pause at 500; frame_start on the last write
        for (int c = 1; c < 1024; c++) begin
            colv = c[7:0];
            if (c == 500) begin
                check_val("wc_at_pause", int'(write_column), 500);
                system_status = 3'd0;
                push_group(8'd77, 1'b0);
                check_val("wc_paused", int'(write_column), 500);
                system_status = 3'd1;
                push(8'd200, 1'b0);
                check_val("wc_resume_cycle", int'(write_column), 500);
            end
            push_group(colv, (c == 1023));
            if (c == 500) begin
                check_val("wc_after_resume", int'(write_column), 501);
            end
        end
        check_val("wc_wrapped", int'(write_column), 0);
        check_val("ready_coincident_fs", int'(buffer_ready), 0);
        check_val("ovf_before_wait", int'(overflow), 0);
        repeat (2) tick();
        check_val("ready_no_fs", int'(buffer_ready), 0);

        // Samples in WAIT_SWAP are dropped and flagged
        push_group(8'd99, 1'b0);
        check_val("ovf_set", int'(overflow), 1);
        check_val("ready_still_0", int'(buffer_ready), 0);
        check_val("wc_wait_held", int'(write_column), 0);

        // Swap banks
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_val("ready_after_swap", int'(buffer_ready), 1);

        // Sweep the read side
        for (int h = 0; h < 1024; h++) begin
            hcount = 11'(h);
            tick();
            exp_rd = (h == 0) ? 25 : (h % 256);
            check_val($sformatf("rd_col%0d", h), int'(signal_out), exp_rd);
        end
        hcount = 11'd1100;
        tick();
        check_val("rd_out_of_range", int'(signal_out), 0);
        check_val("ovf_sticky", int'(overflow), 1);

        // Error status clears column and accumulator; read bank stays displayed
        hcount = 11'd5;
        push_group(8'd1, 1'b0);
        check_val("wc_bank2_first", int'(write_column), 1);
        push(8'd50, 1'b0);
        push(8'd50, 1'b0);
        system_status = 3'd2;
        tick();
        check_val("wc_error_clear", int'(write_column), 0);
        check_val("rd_during_error", int'(signal_out), 5);
        system_status = 3'd1;
        tick();
        push(8'd8, 1'b0);
        push(8'd8, 1'b0);
        check_val("wc_restart_partial", int'(write_column), 0);
        push(8'd8, 1'b0);
        push(8'd8, 1'b0);
        check_val("wc_restart_first", int'(write_column), 1);

        // Advance to column 300 then reset asynchronously
        for (int c = 1; c < 300; c++) begin
            push_group(8'd3, 1'b0);
        end
        check_val("wc_300", int'(write_column), 300);
        hcount = 11'd10;
        tick();
        check_val("rd_pre_reset", int'(signal_out), 10);
        reset = 1'b1;
        #2;
        check_val("arst_signal_out", int'(signal_out), 0);
        check_val("arst_buffer_ready", int'(buffer_ready), 0);
        check_val("arst_write_column", int'(write_column), 0);
        check_val("arst_overflow", int'(overflow), 0);
        tick();
        reset = 1'b0;
        tick();
        check_val("post_reset_wc", int'(write_column), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
